// File: rtl/byte_mem_pkg.sv
// Shared types and constants for the byte-wide memory arbiter.
// lane() maps a big-endian byte index (0 = MSB) to its byte of a 32-bit word.
package byte_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int   BEATS  = 4;
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    function automatic logic [7:0] lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/byte_mem_arbiter_if.sv
// Bundle of the fetch, data and byte-memory signals around the arbiter.
// slave = arbiter view, master = requesters + memory array view.
interface byte_mem_arbiter_if #(parameter int ADDR_W = 16);

    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ack;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_ack;
    logic [31:0]       d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_we, mem_wdata, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker: a lone request wins, a tie goes to the
// requester that did not win last time.
import byte_mem_pkg::*;

module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = REQ_IF;
        if (req[REQ_IF] && req[REQ_D])
            grant = ~last_grant;
        else if (req[REQ_D])
            grant = REQ_D;
    end

endmodule

// File: rtl/byte_mem_arbiter.sv
// Shares one byte-wide memory port between fetch and data requesters; each
// grant runs four big-endian byte beats over one aligned 32-bit word.
import byte_mem_pkg::*;

module byte_mem_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    byte_mem_arbiter_if.slave bus
);

    state_t            state, state_nx;
    logic [1:0]        beat;
    logic              gid, last_grant, grant, we_r, any_req, last_beat, in_xfer;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata_r, asm_r, asm_nx, if_rdata_r, d_rdata_r;

    assign any_req   = bus.if_req | bus.d_req;
    assign last_beat = (beat == 2'(BEATS - 1));
    assign in_xfer   = (state == XFER);

    rr_arbiter2 u_rr (
        .req        ({bus.d_req, bus.if_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = XFER;
            XFER:    if (last_beat) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Assembly word with the current beat's byte already merged, so the final
    // beat can be handed straight to the rdata register on the XFER->RESP edge.
    always_comb begin
        asm_nx = asm_r;
        case (beat)
            2'd0:    asm_nx[31:24] = bus.mem_rdata;
            2'd1:    asm_nx[23:16] = bus.mem_rdata;
            2'd2:    asm_nx[15:8]  = bus.mem_rdata;
            default: asm_nx[7:0]   = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= 2'd0;
            last_grant <= REQ_D;
            gid        <= REQ_IF;
            we_r       <= 1'b0;
            base       <= '0;
            wdata_r    <= '0;
            asm_r      <= '0;
            if_rdata_r <= '0;
            d_rdata_r  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (any_req) begin
                    gid        <= grant;
                    last_grant <= grant;
                    beat       <= 2'd0;
                    if (grant == REQ_D) begin
                        base    <= {bus.d_addr[ADDR_W-1:2], 2'b00};
                        we_r    <= bus.d_we;
                        wdata_r <= bus.d_wdata;
                    end else begin
                        base    <= {bus.if_addr[ADDR_W-1:2], 2'b00};
                        we_r    <= 1'b0;
                    end
                end
                XFER: begin
                    beat <= beat + 2'd1;
                    if (!we_r) begin
                        asm_r <= asm_nx;
                        if (last_beat) begin
                            if (gid == REQ_IF) if_rdata_r <= asm_nx;
                            else               d_rdata_r  <= asm_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // base is word aligned, so base + beat never carries out of the word.
    assign bus.mem_addr  = in_xfer ? (base + ADDR_W'(beat)) : '0;
    assign bus.mem_we    = in_xfer & we_r;
    assign bus.mem_wdata = (in_xfer && we_r) ? lane(wdata_r, beat) : 8'h00;
    assign bus.if_ack    = (state == RESP) && (gid == REQ_IF);
    assign bus.d_ack     = (state == RESP) && (gid == REQ_D);
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.busy      = (state != IDLE);

endmodule
